ulpi_rx_packet_decoder: RTL and testbench

Receive-side stage between the ULPI PHY data bus and the USB protocol state machine. It separates RXCMD bytes from USB packet bytes and frames each received packet. It validates the PID and the CRC5/CRC16, and decodes token fields. It emits the payload as a byte stream followed by a one-cycle packet summary, so the protocol FSM no longer pattern-matches raw bus bytes.

---
 rtl/ulpi_rx_packet_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_ulpi_rx_packet_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_rx_packet_decoder.sv
// ULPI receive-side decoder: splits RXCMDs from USB bytes, frames packets,
// checks PID/CRC5/CRC16, decodes tokens and streams DATAx payload bytes.
module ulpi_rx_packet_decoder #(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic             CLKOUT,
  input  logic             RESET,
  input  logic             DIR,
  input  logic             NXT,
  input  logic [7:0]       data_in,
  output logic [1:0]       linestate,
  output logic             rx_active,
  output logic [7:0]       rx_byte,
  output logic             rx_byte_valid,
  output logic             pkt_done,
  output logic [3:0]       pkt_pid,
  output logic [1:0]       pkt_type,
  output logic [6:0]       tok_addr,
  output logic [3:0]       tok_endp,
  output logic [CNT_W-1:0] pkt_len,
  output logic             pid_err,
  output logic             crc_err,
  output logic             rx_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TURN = 3'd1,
    S_RX   = 3'd2,
    S_BODY = 3'd3,
    S_END  = 3'd4
  } state_t;

  localparam logic [1:0] TYPE_TOKEN = 2'b00;
  localparam logic [1:0] TYPE_DATA  = 2'b01;
  localparam logic [1:0] TYPE_HS    = 2'b10;
  localparam logic [1:0] TYPE_SPEC  = 2'b11;

  localparam logic [CNT_W-1:0] REL_LIM = CNT_W'(MAX_PAYLOAD + 32'd2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
  localparam logic [15:0]      CRC16_RES = 16'hB001;
  localparam logic [4:0]       CRC5_RES  = 5'b01100;

  state_t           state_q, state_d;
  logic             dir_q;
  logic [7:0]       pid_q;
  logic [CNT_W-1:0] body_cnt;
  logic [7:0]       hold0, hold1;
  logic [7:0]       tok_b1, tok_b2;
  logic [15:0]      crc16_q;
  logic             rxerr_q, ovr_q;

  logic             dir_rise_c, rxcmd_c, usb_byte_c, body_byte_c, rx_end_c;
  logic             finish_c, abort_c, emit_c, rxerr_set_c;
  logic [1:0]       cur_type_c;
  logic             done_pid_err_c, done_crc_err_c, done_rx_err_c;
  logic [CNT_W-1:0] done_len_c;

  // Reflected CRC16 (poly 0xA001), one byte LSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  // CRC5 residual over 11 field bits plus 5 CRC bits, LSB-first.
  function automatic logic [4:0] crc5_residual(input logic [15:0] bits);
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 0; i < 16; i++) begin
      fb = c[4] ^ bits[i];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'b00101;
    end
    return c;
  endfunction

  function automatic logic [1:0] type_of(input logic [1:0] pid_lo);
    case (pid_lo)
      2'b01:   return TYPE_TOKEN;
      2'b11:   return TYPE_DATA;
      2'b10:   return TYPE_HS;
      default: return TYPE_SPEC;
    endcase
  endfunction

  always_ff @(posedge CLKOUT) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (dir_rise_c) state_d = S_TURN;
      S_TURN: state_d = DIR ? S_RX : S_IDLE;
      S_RX: begin
        if (!DIR)     state_d = S_IDLE;
        else if (NXT) state_d = S_BODY;
      end
      S_BODY: if (finish_c) state_d = S_END;
      S_END:  state_d = dir_rise_c ? S_TURN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus classification and end-of-packet summary.
  always_comb begin
    dir_rise_c  = DIR & ~dir_q;
    rxcmd_c     = DIR & dir_q & ~NXT & (state_q != S_TURN);
    usb_byte_c  = DIR & NXT & ((state_q == S_RX) | (state_q == S_BODY));
    body_byte_c = usb_byte_c & (state_q == S_BODY);
    rx_end_c    = rxcmd_c & ~data_in[4];
    rxerr_set_c = rxcmd_c & (data_in[5:4] == 2'b11) &
                  ((state_q == S_RX) | (state_q == S_BODY));
    finish_c    = (state_q == S_BODY) & (~DIR | rx_end_c);
    abort_c     = (state_q == S_BODY) & ~DIR;
    cur_type_c  = type_of(pid_q[1:0]);
    emit_c      = body_byte_c & (cur_type_c == TYPE_DATA) &
                  (body_cnt >= CNT_TWO) & (body_cnt < REL_LIM);

    done_pid_err_c = (pid_q[7:4] != ~pid_q[3:0]);
    done_rx_err_c  = rxerr_q | ovr_q | abort_c;
    done_crc_err_c = 1'b0;
    done_len_c     = '0;
    case (cur_type_c)
      TYPE_TOKEN: done_crc_err_c = (body_cnt != CNT_TWO) |
                                   (crc5_residual({tok_b2, tok_b1}) != CRC5_RES);
      TYPE_DATA: begin
        done_crc_err_c = (body_cnt < CNT_TWO) | (crc16_q != CRC16_RES);
        if (body_cnt >= CNT_TWO) done_len_c = body_cnt - CNT_TWO;
      end
      TYPE_HS:   done_crc_err_c = (body_cnt != '0);
      default:   done_crc_err_c = 1'b0;
    endcase
  end

  always_ff @(posedge CLKOUT) begin
    if (RESET) begin
      dir_q         <= 1'b0;
      pid_q         <= '0;
      body_cnt      <= '0;
      hold0         <= '0;
      hold1         <= '0;
      tok_b1        <= '0;
      tok_b2        <= '0;
      crc16_q       <= 16'hFFFF;
      rxerr_q       <= 1'b0;
      ovr_q         <= 1'b0;
      linestate     <= '0;
      rx_active     <= 1'b0;
      rx_byte       <= '0;
      rx_byte_valid <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_pid       <= '0;
      pkt_type      <= '0;
      tok_addr      <= '0;
      tok_endp      <= '0;
      pkt_len       <= '0;
      pid_err       <= 1'b0;
      crc_err       <= 1'b0;
      rx_err        <= 1'b0;
    end else begin
      dir_q         <= DIR;
      rx_byte_valid <= 1'b0;
      pkt_done      <= 1'b0;
      pkt_len       <= '0;
      pid_err       <= 1'b0;
      crc_err       <= 1'b0;
      rx_err        <= 1'b0;

      if (rxcmd_c) begin
        linestate <= data_in[1:0];
        rx_active <= data_in[4];
      end
      if (!DIR) rx_active <= 1'b0;

      if (state_q == S_TURN) begin
        rxerr_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (rxerr_set_c) rxerr_q <= 1'b1;

      if (usb_byte_c && (state_q == S_RX)) begin
        pid_q    <= data_in;
        body_cnt <= '0;
        crc16_q  <= 16'hFFFF;
      end

      // Body bytes: CRC, token capture, and a two-deep hold-back for the CRC16 bytes.
      if (body_byte_c) begin
        if (body_cnt != CNT_MAX) body_cnt <= body_cnt + CNT_W'(1);
        crc16_q <= crc16_step(crc16_q, data_in);
        if (body_cnt == '0)          tok_b1 <= data_in;
        if (body_cnt == CNT_W'(1))   tok_b2 <= data_in;
        hold0 <= data_in;
        hold1 <= hold0;
        if (emit_c) begin
          rx_byte       <= hold1;
          rx_byte_valid <= 1'b1;
        end
        if ((cur_type_c == TYPE_DATA) && (body_cnt >= REL_LIM)) ovr_q <= 1'b1;
      end

      if (finish_c) begin
        pkt_done <= 1'b1;
        pkt_pid  <= pid_q[3:0];
        pkt_type <= cur_type_c;
        pkt_len  <= done_len_c;
        pid_err  <= done_pid_err_c;
        crc_err  <= done_crc_err_c;
        rx_err   <= done_rx_err_c;
        if (cur_type_c == TYPE_TOKEN) begin
          tok_addr <= tok_b1[6:0];
          tok_endp <= {tok_b2[2:0], tok_b1[7]};
        end
      end
    end
  end

endmodule

// File: tb/tb_ulpi_rx_packet_decoder.sv
// Directed self-checking bench for ulpi_rx_packet_decoder.
module tb_ulpi_rx_packet_decoder;

  localparam int unsigned CNT_W = 7;

  logic             CLKOUT = 1'b0;
  logic             RESET, DIR, NXT;
  logic [7:0]       data_in;
  logic [1:0]       linestate;
  logic             rx_active;
  logic [7:0]       rx_byte;
  logic             rx_byte_valid;
  logic             pkt_done;
  logic [3:0]       pkt_pid;
  logic [1:0]       pkt_type;
  logic [6:0]       tok_addr;
  logic [3:0]       tok_endp;
  logic [CNT_W-1:0] pkt_len;
  logic             pid_err, crc_err, rx_err;

  ulpi_rx_packet_decoder #(.MAX_PAYLOAD(64), .CNT_W(CNT_W)) dut (
    .CLKOUT(CLKOUT), .RESET(RESET), .DIR(DIR), .NXT(NXT), .data_in(data_in),
    .linestate(linestate), .rx_active(rx_active), .rx_byte(rx_byte),
    .rx_byte_valid(rx_byte_valid), .pkt_done(pkt_done), .pkt_pid(pkt_pid),
    .pkt_type(pkt_type), .tok_addr(tok_addr), .tok_endp(tok_endp),
    .pkt_len(pkt_len), .pid_err(pid_err), .crc_err(crc_err), .rx_err(rx_err)
  );

  always #5 CLKOUT = ~CLKOUT;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         cyc_n = 0;
  int         first_valid_cyc = -1;
  int         byte3_cyc = -1;
  int         prev_done;
  logic [7:0] got[$];
  logic [7:0] q[$];
  logic [3:0] c_pid;
  logic [1:0] c_type;
  logic [CNT_W-1:0] c_len;
  logic       c_pe, c_ce, c_re;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle; outputs sampled 1 time unit after the rising edge.
  task automatic cyc(input logic d, input logic n, input logic [7:0] b);
    DIR = d; NXT = n; data_in = b;
    @(posedge CLKOUT); #1;
    cyc_n++;
    if (rx_byte_valid) begin
      got.push_back(rx_byte);
      if (first_valid_cyc < 0) first_valid_cyc = cyc_n;
    end
    if (pkt_done) begin
      done_cnt++;
      c_pid = pkt_pid; c_type = pkt_type; c_len = pkt_len;
      c_pe = pid_err; c_ce = crc_err; c_re = rx_err;
    end
  endtask

  task automatic send(input logic [7:0] pkt[$], input int err_at, input bit abort);
    got.delete();
    first_valid_cyc = -1;
    byte3_cyc = -1;
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h11);
    foreach (pkt[i]) begin
      if (i == err_at) cyc(1, 0, 8'h31);
      cyc(1, 1, pkt[i]);
      if (i == 3) byte3_cyc = cyc_n;
    end
    if (!abort) cyc(1, 0, 8'h01);
    cyc(0, 0, 8'h00);
  endtask

  initial begin
    RESET = 1'b1; DIR = 1'b0; NXT = 1'b0; data_in = 8'h00;
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    chk("rst_linestate", 32'(linestate), 32'h0);
    chk("rst_rx_active", 32'(rx_active), 32'h0);
    chk("rst_valid_done", 32'({rx_byte_valid, pkt_done}), 32'h0);
    chk("rst_summary", 32'({pkt_pid, pkt_type, tok_addr, tok_endp, pkt_len}), 32'h0);
    RESET = 1'b0;
    cyc(0, 0, 8'h00);

    // SETUP token, addr 0 ep 0
    prev_done = done_cnt;
    q = '{8'h2D, 8'h00, 8'h10};
    send(q, -1, 1'b0);
    chk("setup_done", 32'(done_cnt), 32'(prev_done + 1));
    chk("setup_pid", 32'(c_pid), 32'hD);
    chk("setup_type", 32'(c_type), 32'h0);
    chk("setup_addr_endp", 32'({tok_addr, tok_endp}), 32'h0);
    chk("setup_errs", 32'({c_pe, c_ce, c_re}), 32'h0);
    chk("setup_no_bytes", 32'(got.size()), 32'h0);
    chk("setup_linestate", 32'(linestate), 32'h1);

    // DATA0 with good CRC16
    prev_done = done_cnt;
    q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    send(q, -1, 1'b0);
    chk("data0_done", 32'(done_cnt), 32'(prev_done + 1));
    chk("data0_nbytes", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("data0_byte", 32'(got[i]), 32'(q[i+1]));
    chk("data0_latency", 32'(first_valid_cyc), 32'(byte3_cyc));
    chk("data0_len", 32'(c_len), 32'd8);
    chk("data0_type", 32'(c_type), 32'h1);
    chk("data0_errs", 32'({c_pe, c_ce, c_re}), 32'h0);
    chk("data0_rx_active_low", 32'(rx_active), 32'h0);

    // DATA0 with corrupted final CRC byte
    q[10] = 8'h95;
    send(q, -1, 1'b0);
    chk("data0_bad_crc", 32'(c_ce), 32'h1);

    // ACK, then a PID with a bad check nibble
    q = '{8'hD2};
    send(q, -1, 1'b0);
    chk("ack_pid", 32'(c_pid), 32'h2);
    chk("ack_type", 32'(c_type), 32'h2);
    chk("ack_errs", 32'({c_pe, c_ce, c_re}), 32'h0);
    q = '{8'h2C};
    send(q, -1, 1'b0);
    chk("bad_pid_err", 32'(c_pe), 32'h1);

    // IN addr 1 ep 1, then with one body bit flipped
    q = '{8'h69, 8'h81, 8'h58};
    send(q, -1, 1'b0);
    chk("in_addr", 32'(tok_addr), 32'h1);
    chk("in_endp", 32'(tok_endp), 32'h1);
    chk("in_errs", 32'({c_pe, c_ce, c_re}), 32'h0);
    q = '{8'h69, 8'h83, 8'h58};
    send(q, -1, 1'b0);
    chk("in_flip_crc", 32'(c_ce), 32'h1);

    // DATA1 with 70 payload bytes: overrun
    q = '{8'h4B};
    for (int i = 0; i < 72; i++) q.push_back(8'(i));
    send(q, -1, 1'b0);
    chk("ovr_nbytes", 32'(got.size()), 32'd64);
    chk("ovr_rx_err", 32'(c_re), 32'h1);

    // RxError RXCMD in the middle of a good DATA0
    q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    send(q, 5, 1'b0);
    chk("rxerr_rx_err", 32'(c_re), 32'h1);
    chk("rxerr_crc_ok", 32'(c_ce), 32'h0);
    chk("rxerr_nbytes", 32'(got.size()), 32'd8);

    // DIR falls mid-packet without RxActive=0
    prev_done = done_cnt;
    q = '{8'h69, 8'h81};
    send(q, -1, 1'b1);
    chk("abort_done", 32'(done_cnt), 32'(prev_done + 1));
    chk("abort_rx_err", 32'(c_re), 32'h1);

    // DIR falls before any PID byte
    cyc(0, 0, 8'h00);
    prev_done = done_cnt;
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h11);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    chk("prepid_no_done", 32'(done_cnt), 32'(prev_done));

    // RESET during a DATA0 body
    prev_done = done_cnt;
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h11);
    q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01};
    foreach (q[i]) cyc(1, 1, q[i]);
    RESET = 1'b1;
    cyc(1, 1, 8'h00);
    RESET = 1'b0;
    chk("midrst_ls_active", 32'({linestate, rx_active}), 32'h0);
    chk("midrst_strobes", 32'({rx_byte_valid, pkt_done, pid_err, crc_err, rx_err}), 32'h0);
    chk("midrst_summary", 32'({pkt_pid, pkt_type, tok_addr, tok_endp, pkt_len}), 32'h0);
    chk("midrst_rx_byte", 32'(rx_byte), 32'h0);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    chk("midrst_no_done", 32'(done_cnt), 32'(prev_done));
    q = '{8'hD2};
    send(q, -1, 1'b0);
    chk("postrst_done", 32'(done_cnt), 32'(prev_done + 1));
    chk("postrst_ack_pid", 32'(c_pid), 32'h2);
    chk("postrst_ack_errs", 32'({c_pe, c_ce, c_re}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
